// File: rtl/spike_volley_encoder.sv
// Temporal spike volley encoder: accepts a volley of per-line spike times and
// replays it as active-low, level-held spike lines over one gamma period.
// A one-deep pending buffer lets the next volley start with no idle cycle.
module spike_volley_encoder #(
  parameter int unsigned NUM_LINES    = 8,
  parameter int unsigned TIME_BITS    = 3,
  parameter int unsigned GAMMA_CYCLES = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_LINES*TIME_BITS-1:0]    in_times,
  input  logic [NUM_LINES-1:0]              in_mask,
  output logic [NUM_LINES-1:0]              out_spikes,
  output logic                              clear,
  output logic [$clog2(GAMMA_CYCLES)-1:0]   timestep,
  output logic                              busy,
  output logic                              period_done
);

  localparam int unsigned TsW = $clog2(GAMMA_CYCLES);
  localparam logic [TsW-1:0] LastTs = TsW'(GAMMA_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                           state_q, state_d;
  logic [TsW-1:0]                   ts_q, ts_d;
  logic [NUM_LINES*TIME_BITS-1:0]   act_times_q, act_times_d;
  logic [NUM_LINES-1:0]             act_mask_q, act_mask_d;
  logic [NUM_LINES*TIME_BITS-1:0]   pend_times_q, pend_times_d;
  logic [NUM_LINES-1:0]             pend_mask_q, pend_mask_d;
  logic                             pend_valid_q, pend_valid_d;
  logic [NUM_LINES-1:0]             spikes_q, spikes_d;
  logic                             clear_q, clear_d;
  logic                             done_q, done_d;
  logic                             xfer;

  // Ready depends on state only so the producer never sees a combinational loop.
  assign in_ready = (state_q == StIdle) || !pend_valid_q;
  assign xfer     = in_valid && in_ready;

  // Next-state: timestep sequencing, pending capture and volley selection at wrap.
  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q;
    act_times_d  = act_times_q;
    act_mask_d   = act_mask_q;
    pend_times_d = pend_times_q;
    pend_mask_d  = pend_mask_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d     = StRun;
          ts_d        = '0;
          act_times_d = in_times;
          act_mask_d  = in_mask;
        end
      end
      StRun: begin
        if (ts_q != LastTs) begin
          ts_d = ts_q + 1'b1;
          if (xfer) begin
            pend_times_d = in_times;
            pend_mask_d  = in_mask;
            pend_valid_d = 1'b1;
          end
        end else begin
          ts_d = '0;
          if (pend_valid_q) begin
            // in_ready is low here, so no transfer competes with the promotion.
            act_times_d  = pend_times_q;
            act_mask_d   = pend_mask_q;
            pend_valid_d = 1'b0;
          end else if (xfer) begin
            act_times_d = in_times;
            act_mask_d  = in_mask;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state so they align with timestep.
  always_comb begin
    spikes_d = '1;
    clear_d  = 1'b0;
    done_d   = 1'b0;
    if (state_d == StRun) begin
      clear_d = (ts_d == '0);
      done_d  = (ts_d == LastTs);
      for (int i = 0; i < NUM_LINES; i++) begin
        spikes_d[i] = !(act_mask_d[i] &&
                        (32'(act_times_d[i*TIME_BITS +: TIME_BITS]) <= 32'(ts_d)));
      end
    end
  end

  // State and output registers; reset aborts any volley and drops pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ts_q         <= '0;
      act_times_q  <= '0;
      act_mask_q   <= '0;
      pend_times_q <= '0;
      pend_mask_q  <= '0;
      pend_valid_q <= 1'b0;
      spikes_q     <= '1;
      clear_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      act_times_q  <= act_times_d;
      act_mask_q   <= act_mask_d;
      pend_times_q <= pend_times_d;
      pend_mask_q  <= pend_mask_d;
      pend_valid_q <= pend_valid_d;
      spikes_q     <= spikes_d;
      clear_q      <= clear_d;
      done_q       <= done_d;
    end
  end

  assign out_spikes  = spikes_q;
  assign clear       = clear_q;
  assign period_done = done_q;
  assign busy        = (state_q == StRun);
  assign timestep    = ts_q;

endmodule

// File: tb/tb_spike_volley_encoder.sv
// Self-checking bench for spike_volley_encoder: directed scenarios plus random
// traffic, checked against a schedule-based model of volley periods.
module tb_spike_volley_encoder;

  localparam int NL = 4;
  localparam int TB = 4;
  localparam int G  = 8;
  localparam int TW = NL * TB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_times = '0;
  logic [NL-1:0] in_mask = '0;
  logic [NL-1:0] out_spikes;
  logic          clear;
  logic [2:0]    timestep;
  logic          busy;
  logic          period_done;

  spike_volley_encoder #(
    .NUM_LINES   (NL),
    .TIME_BITS   (TB),
    .GAMMA_CYCLES(G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_times   (in_times),
    .in_mask    (in_mask),
    .out_spikes (out_spikes),
    .clear      (clear),
    .timestep   (timestep),
    .busy       (busy),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  // Each accepted volley occupies the cycles [start, start+G).
  typedef struct {
    int            start;
    logic [TW-1:0] times;
    logic [NL-1:0] mask;
  } vol_t;

  vol_t sched[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Compare all outputs against the period covering the current cycle.
  task automatic check_outputs(output logic exp_ready);
    int            t;
    int            pend;
    logic [TW-1:0] et;
    logic [NL-1:0] em;
    logic [NL-1:0] sp;
    t = -1; pend = 0; et = '0; em = '0;
    foreach (sched[i]) begin
      if (cyc >= sched[i].start && cyc < sched[i].start + G) begin
        t  = cyc - sched[i].start;
        et = sched[i].times;
        em = sched[i].mask;
      end
      if (sched[i].start > cyc) pend++;
    end
    sp = '1;
    if (t >= 0) begin
      for (int i = 0; i < NL; i++) begin
        if (em[i] && int'(et[i*TB +: TB]) <= t) sp[i] = 1'b0;
      end
    end
    exp_ready = (pend == 0);
    check_val("out_spikes", 32'(out_spikes), 32'(sp));
    check_val("clear", 32'(clear), 32'(t == 0));
    check_val("busy", 32'(busy), 32'(t >= 0));
    check_val("period_done", 32'(period_done), 32'(t == G - 1));
    check_val("timestep", 32'(timestep), (t >= 0) ? t : 0);
    check_val("in_ready", 32'(in_ready), 32'(exp_ready));
  endtask

  // One cycle: check, drive, clock, schedule any accepted volley.
  task automatic step(input logic v, input logic [TW-1:0] t, input logic [NL-1:0] m,
                      output logic acc);
    logic rdy;
    vol_t nv;
    int   st;
    check_outputs(rdy);
    in_valid = v;
    in_times = t;
    in_mask  = m;
    acc = v && rdy;
    @(posedge clk);
    if (acc) begin
      st = cyc + 1;
      if (sched.size() > 0 && sched[$].start + G > st) st = sched[$].start + G;
      nv.start = st;
      nv.times = t;
      nv.mask  = m;
      sched.push_back(nv);
    end
    cyc++;
    @(negedge clk);
    while (sched.size() > 0 && sched[0].start + G <= cyc) void'(sched.pop_front());
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_spikes", 32'(out_spikes), 32'(4'hF));
    check_val("rst_busy", 32'(busy), 32'(1'b0));
    check_val("rst_clear", 32'(clear), 32'(1'b0));
    check_val("rst_done", 32'(period_done), 32'(1'b0));
    check_val("rst_ready", 32'(in_ready), 32'(1'b1));
    check_val("rst_timestep", 32'(timestep), 32'(0));
    sched.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc;
    logic          v3_done;
    int            acc_k;
    logic          hold;
    logic          rv;
    logic [TW-1:0] rt;
    logic [NL-1:0] rm;

    @(negedge clk);

    // Single volley: times {0,3,7,5}, all lines enabled.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      case (k)
        1: begin
          check_val("tp1_c1_spk", 32'(out_spikes), 32'(4'b1110));
          check_val("tp1_c1_clear", 32'(clear), 32'(1'b1));
        end
        4: check_val("tp1_c4_spk", 32'(out_spikes), 32'(4'b1100));
        6: check_val("tp1_c6_spk", 32'(out_spikes), 32'(4'b0100));
        8: begin
          check_val("tp1_c8_spk", 32'(out_spikes), 32'(4'b0000));
          check_val("tp1_c8_done", 32'(period_done), 32'(1'b1));
        end
        9: begin
          check_val("tp1_c9_spk", 32'(out_spikes), 32'(4'b1111));
          check_val("tp1_c9_busy", 32'(busy), 32'(1'b0));
        end
        default: ;
      endcase
      step(k == 0, 16'h5730, 4'hF, acc);
    end

    // Mask and out-of-range time.
    do_reset();
    for (int k = 0; k < 19; k++) begin
      if (k == 2) check_val("tp2_t1_spk", 32'(out_spikes), 32'(4'b1111));
      if (k == 3) check_val("tp2_t2_spk", 32'(out_spikes), 32'(4'b1010));
      if (k == 16) check_val("tp2_time9_spk", 32'(out_spikes), 32'(4'b1000));
      step(k == 0 || k == 8, (k == 8) ? 16'h9222 : 16'h2222, (k == 8) ? 4'hF : 4'b0101, acc);
    end

    // Back-to-back plus backpressure on a third volley.
    do_reset();
    v3_done = 1'b0;
    acc_k   = -1;
    for (int k = 0; k < 27; k++) begin
      if (k == 1) check_val("tp3_clear1", 32'(clear), 32'(1'b1));
      if (k == 5) check_val("tp3_ready_low", 32'(in_ready), 32'(1'b0));
      if (k == 9) begin
        check_val("tp3_clear9", 32'(clear), 32'(1'b1));
        check_val("tp3_ready9", 32'(in_ready), 32'(1'b1));
      end
      if (k == 16) check_val("tp3_clear16", 32'(clear), 32'(1'b0));
      if (k == 17) check_val("tp3_clear17", 32'(clear), 32'(1'b1));
      if (k == 0)      step(1'b1, 16'h5730, 4'hF, acc);
      else if (k == 4) step(1'b1, 16'h0123, 4'hF, acc);
      else if (k >= 5 && !v3_done) begin
        step(1'b1, 16'h7777, 4'b1010, acc);
        if (acc) begin
          v3_done = 1'b1;
          acc_k   = k;
        end
      end else step(1'b0, '0, '0, acc);
    end
    check_val("tp3_accept_cycle", 32'(acc_k), 32'(9));

    // Transfer on the last timestep with pending empty.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      if (k == 9) begin
        check_val("tp4_clear", 32'(clear), 32'(1'b1));
        check_val("tp4_spk", 32'(out_spikes), 32'(4'b1100));
      end
      step(k == 0 || k == 8, (k == 8) ? 16'h0000 : 16'h1111, (k == 8) ? 4'b0011 : 4'hF, acc);
    end

    // Reset mid-period with a pending volley.
    do_reset();
    for (int k = 0; k < 5; k++) step(k == 0 || k == 2, 16'h3210, 4'hF, acc);
    check_val("tp5_busy_pre", 32'(busy), 32'(1'b1));
    check_val("tp5_ts_pre", 32'(timestep), 32'(4));
    do_reset();
    check_val("tp5_ready_post", 32'(in_ready), 32'(1'b1));
    for (int k = 0; k < 12; k++) step(1'b0, '0, '0, acc);

    // Random traffic with hold-while-stalled producer behaviour.
    do_reset();
    hold = 1'b0;
    rv = 1'b0; rt = '0; rm = '0;
    for (int n = 0; n < 800; n++) begin
      if (!hold) begin
        rv = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < NL; i++) rt[i*TB +: TB] = 4'($urandom_range(0, 10));
        rm = 4'($urandom);
      end
      step(rv, rt, rm, acc);
      hold = rv && !acc;
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
        hold = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_volley_encoder.md
# spike_volley_encoder

Temporal spike transmitter for an excitatory column. It accepts a volley of per-line spike times through a valid/ready handshake and replays it as active-low, level-held spike lines across one gamma period of GAMMA_CYCLES timesteps. It asserts `clear` on the first timestep of each period, which makes it the driver for the `in_spikes`/`clear` inputs of the column and the lateral inhibition stage. A one-deep pending buffer lets consecutive volleys play back-to-back with no idle cycle.

## Interface
- NUM_LINES, default 8: number of spike lines in the volley.
- TIME_BITS, default 3: width of each spike-time field.
- GAMMA_CYCLES, default 8: timesteps per period. Must be ≥2 and ≤2^TIME_BITS.
- clk  input  1: clock.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: a volley is presented.
- in_ready  output  1: the encoder can accept a volley this cycle.
- in_times  input  NUM_LINES*TIME_BITS: spike time of line i in bits [i*TIME_BITS +: TIME_BITS].
- in_mask  input  NUM_LINES: 1 = line i fires, 0 = line i never fires this period.
- out_spikes  output  NUM_LINES: active-low spike lines. 1 = not yet spiked, 0 = spiked; held until the period ends.
- clear  output  1: high during timestep 0 of every period.
- timestep  output  $clog2(GAMMA_CYCLES): current timestep. 0 when idle.
- busy  output  1: a period is playing.
- period_done  output  1: one-cycle pulse during the last timestep (GAMMA_CYCLES-1).

## Operation
- States: IDLE and RUN. Registers: active volley (times and mask), pending volley plus pending_valid, timestep counter.
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready.
  - The producer must hold in_times and in_mask stable while in_valid is high and in_ready is low.
- in_ready = 1 in IDLE. In RUN, in_ready = !pending_valid. It is combinational from state only, never from in_valid.
- IDLE, transfer: load active, go to RUN, timestep = 0.
- RUN, timestep < GAMMA_CYCLES-1: increment timestep. A transfer loads pending and sets pending_valid.
- RUN, timestep == GAMMA_CYCLES-1, next volley source in priority order:
  1. pending, if pending_valid: promote it to active and clear pending_valid. in_ready is low this cycle, so no transfer can occur.
  2. Otherwise, a transfer in this cycle goes directly to active.
  3. Otherwise, go to IDLE.
  - In cases 1 and 2: timestep wraps to 0 and state stays RUN, with no bubble.
- Spike generation is a registered output. During any RUN cycle with timestep T, out_spikes[i] = 0 iff mask[i] && time[i] ≤ T. Otherwise it is 1.
- Times ≥ GAMMA_CYCLES never fire.
- At each new period all lines return to 1, except lines whose time is 0, which are 0 in the clear cycle.
- clear = (state==RUN && timestep==0). busy = (state==RUN).
- IDLE: out_spikes all 1, clear 0, period_done 0.

## Timing
- Reset (asynchronous, while rst_n low): state IDLE, pending_valid 0, timestep 0, out_spikes all 1, clear 0, busy 0, period_done 0. in_ready therefore reads 1.
- Reset mid-period aborts the volley immediately and drops any pending volley.
- Latency: transfer at edge k in IDLE means clear=1, timestep=0 in cycle k+1. Line i first reads 0 in cycle k+1+time[i].
- Period length is exactly GAMMA_CYCLES cycles. Back-to-back volleys give clear every GAMMA_CYCLES cycles.
- Simultaneous transfer and wrap with pending empty: the new volley starts in the very next cycle.
- in_valid held with in_ready low: no state change and no data loss.

## Test plan
- NUM_LINES=4, GAMMA_CYCLES=8, single volley times {0,3,7,5}, mask 4'b1111, transfer at cycle 0:
  - cycle 1: clear=1, out_spikes=4'b1110.
  - cycle 4: 4'b1100.
  - cycle 6: 4'b0100.
  - cycle 8: 4'b0000, period_done=1.
  - cycle 9: IDLE, out_spikes=4'b1111, busy=0.
- Mask and out-of-range times: mask 4'b0101 with times {2,2,2,2}: only lines 0 and 2 fall, at timestep 2. With TIME_BITS=4, GAMMA_CYCLES=8, a time of 9 never fires.
- Back-to-back: second volley transferred at timestep 3 of the first. in_ready drops until the wrap, and clear pulses at cycles 1 and 9 with no gap.
- Backpressure: a third volley is held valid while pending is full. It is accepted in the cycle after the wrap, in_ready returns high then, and the third period starts at cycle 17.
- Transfer exactly on the last timestep with pending empty: the next cycle has clear=1 and lines with time 0 are already low.
- rst_n pulled low at timestep 4 with a pending volley: outputs are immediately all 1 and busy=0. After release, in_ready=1 and no pending volley plays.
